// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter slice.
// State encoding and byte width used by arbiter and interface.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle seen by the UART transmit arbiter.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
);

    logic [N-1:0]             req;
    logic [UART_DATA_W*N-1:0] req_data;
    logic [N-1:0]             ack;
    logic                     tx_start;
    logic [UART_DATA_W-1:0]   tx_data;
    logic                     tx_busy;
    logic [ID_W-1:0]          grant_id;
    logic                     active;
    logic                     timeout_err;

    modport master (
        input  req, req_data, tx_busy,
        output ack, tx_start, tx_data,
        output grant_id, active, timeout_err
    );

    modport slave (
        output req, req_data, tx_busy,
        input  ack, tx_start, tx_data,
        input  grant_id, active, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr.
// Shared by transmit arbiter and receive-side distributor.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    logic [2*N-1:0]  rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   sum;

    // rotate so bit 0 is the pointer position, then add the offset back
    assign rot = {req, req} >> ptr;

    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = ID_W'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
    end

    assign found = |req;
    assign idx   = sum[ID_W-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N requesters.
// Latches a byte, pulses start/ack, then follows tx_busy to frame end.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N            = 4,
    parameter int ID_W         = 2,
    parameter int BUSY_TIMEOUT = 4
) (
    input logic             clk,
    input logic             rst_n,
    uart_tx_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_t                 state, state_d;
    logic [ID_W-1:0]        ptr, ptr_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]        gid_q, gid_d;
    logic                   act_q, act_d;
    logic                   err_q, err_d;

    logic                   found;
    logic [ID_W-1:0]        idx;
    logic [ID_W-1:0]        ptr_nxt;
    logic [UART_DATA_W-1:0] bytes [N];

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (found),
        .idx   (idx)
    );

    always_comb begin
        for (int i = 0; i < N; i++)
            bytes[i] = bus.req_data[i*UART_DATA_W +: UART_DATA_W];
    end

    // wrap at N-1 so non-power-of-two N never points past the last requester
    assign ptr_nxt = (gid_q == ID_W'(N - 1)) ? '0 : gid_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            data_q <= '0;
            gid_q  <= '0;
            act_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            cnt    <= cnt_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            act_q  <= act_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        data_d  = data_q;
        gid_d   = gid_q;
        act_d   = act_q;
        err_d   = err_q;
        unique case (state)
            IDLE: begin
                if (!bus.tx_busy && found) begin
                    data_d  = bytes[idx];
                    gid_d   = idx;
                    act_d   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    act_d   = 1'b0;
                    ptr_d   = ptr_nxt;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    act_d   = 1'b0;
                    ptr_d   = ptr_nxt;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_start    = (state == START);
    assign bus.ack         = (state == START) ? (N'(1) << gid_q) : '0;
    assign bus.tx_data     = data_q;
    assign bus.grant_id    = gid_q;
    assign bus.active      = act_q;
    assign bus.timeout_err = err_q;

endmodule
